// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares one single-port, synchronous-read data DRAM between two masters:
//   m0 (miniCPU MEM-stage data port) and m1 (debug/boot loader or DMA).
//   Each transaction is req/gnt/done: gnt in cycle N (combinational),
//   DRAM access in N+1, done + read data in N+2. A new grant may be issued
//   in the done cycle, so sustained throughput is one transaction per 2 cycles.
//
// Parameters
//   ADDR_W     address width
//   DATA_W     data width
//   PRIO_FIXED 0 = round-robin between contenders, 1 = m0 always wins ties
//
// Ports
//   clk, rst                       clock (rising edge), sync active-high reset
//   mX_req/we/adr/wdin             master X request, sampled only in its gnt cycle
//   mX_gnt                         request accepted this cycle
//   mX_done / mX_rd                one-cycle completion pulse / read data
//   dram_adr/dram_wdin/dram_we     DRAM command, strobe only during ACCESS
//   dram_rd                        DRAM read data, one cycle after the address
//   owner                          master of the in-flight or last transaction
module dram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_wdin,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_wdin,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rd,
  output logic [ADDR_W-1:0] dram_adr,
  output logic [DATA_W-1:0] dram_wdin,
  output logic              dram_we,
  input  logic [DATA_W-1:0] dram_rd,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  logic                last_grant;
  logic [ADDR_W-1:0]   adr_p1;
  logic [DATA_W-1:0]   wdin_p1;
  logic                we_p1;
  logic                id_p1;
  logic                dram_we_p1;
  logic                m0_done_p2;
  logic                m1_done_p2;

  logic                win_vld;
  logic                win_id;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_adr;
  logic [DATA_W-1:0]   sel_wdin;

  // Arbitration: runs in IDLE and DONE only, suppressed while rst is high.
  // On a tie, round-robin picks the master that did not win last time;
  // last_grant resets to 1 so m0 takes the first tie.
  always_comb begin
    win_vld = !rst && (state != ACCESS) && (m0_req || m1_req);
    win_id  = 1'b0;
    if (m0_req && m1_req) begin
      win_id = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
    end else if (m1_req) begin
      win_id = 1'b1;
    end
    sel_we   = win_id ? m1_we   : m0_we;
    sel_adr  = win_id ? m1_adr  : m0_adr;
    sel_wdin = win_id ? m1_wdin : m0_wdin;
  end

  assign m0_gnt = win_vld && !win_id;
  assign m1_gnt = win_vld &&  win_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      adr_p1     <= '0;
      wdin_p1    <= '0;
      we_p1      <= 1'b0;
      id_p1      <= 1'b0;
      dram_we_p1 <= 1'b0;
      m0_done_p2 <= 1'b0;
      m1_done_p2 <= 1'b0;
    end else begin
      dram_we_p1 <= 1'b0;
      m0_done_p2 <= 1'b0;
      m1_done_p2 <= 1'b0;
      case (state)
        // Grant stage -> ACCESS: latch the winner's command.
        IDLE, DONE: begin
          if (win_vld) begin
            adr_p1     <= sel_adr;
            wdin_p1    <= sel_wdin;
            we_p1      <= sel_we;
            id_p1      <= win_id;
            last_grant <= win_id;
            dram_we_p1 <= sel_we;
            state      <= ACCESS;
          end else begin
            state      <= IDLE;
          end
        end
        // ACCESS -> DONE: DRAM sees the command this cycle, data returns next.
        ACCESS: begin
          m0_done_p2 <= !id_p1;
          m1_done_p2 <=  id_p1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address and write data hold the last latched command outside ACCESS;
  // only the strobe is qualified. we_p1 stays valid through DONE because a
  // back-to-back grant only overwrites it at the end of the DONE cycle.
  assign dram_adr  = adr_p1;
  assign dram_wdin = wdin_p1;
  assign dram_we   = dram_we_p1;
  assign owner     = id_p1;
  assign m0_done   = m0_done_p2;
  assign m1_done   = m1_done_p2;
  assign m0_rd     = (m0_done_p2 && !we_p1) ? dram_rd : '0;
  assign m1_rd     = (m1_done_p2 && !we_p1) ? dram_rd : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_adr, m0_wdin, m1_adr, m1_wdin;

  // u_rr: round-robin instance, u_fx: fixed-priority instance (shared stimulus)
  logic        a_m0_gnt, a_m0_done, a_m1_gnt, a_m1_done, a_dram_we, a_owner;
  logic [31:0] a_m0_rd, a_m1_rd, a_dram_adr, a_dram_wdin;
  logic [31:0] a_dram_rd = '0;
  logic        b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done, b_dram_we, b_owner;
  logic [31:0] b_m0_rd, b_m1_rd, b_dram_adr, b_dram_wdin;
  logic [31:0] b_dram_rd = '0;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  int checks = 0;
  int errors = 0;

  dram_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_FIXED(0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdin(m0_wdin),
    .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rd(a_m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdin(m1_wdin),
    .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rd(a_m1_rd),
    .dram_adr(a_dram_adr), .dram_wdin(a_dram_wdin), .dram_we(a_dram_we),
    .dram_rd(a_dram_rd), .owner(a_owner)
  );

  dram_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_FIXED(1)) u_fx (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdin(m0_wdin),
    .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rd(b_m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdin(m1_wdin),
    .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rd(b_m1_rd),
    .dram_adr(b_dram_adr), .dram_wdin(b_dram_wdin), .dram_we(b_dram_we),
    .dram_rd(b_dram_rd), .owner(b_owner)
  );

  // Synchronous-read DRAM models, one per instance.
  always @(posedge clk) begin
    if (a_dram_we) mem_a[a_dram_adr[7:0]] <= a_dram_wdin;
    a_dram_rd <= mem_a[a_dram_adr[7:0]];
    if (b_dram_we) mem_b[b_dram_adr[7:0]] <= b_dram_wdin;
    b_dram_rd <= mem_b[b_dram_adr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [7:0] a_g0_t, a_g1_t, a_d0_t, a_d1_t, b_g0_t, b_d0_t;

  initial begin
    a_g0_t = 8'h11; a_g1_t = 8'h44; a_d0_t = 8'h44; a_d1_t = 8'h10;
    b_g0_t = 8'h55; b_d0_t = 8'h54;
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    mem_a[8'h10] = 32'hDEADBEEF; mem_b[8'h10] = 32'hDEADBEEF;
    mem_a[8'h20] = 32'h0BADF00D; mem_b[8'h20] = 32'h0BADF00D;
    mem_a[8'h40] = 32'h11111111; mem_b[8'h40] = 32'h11111111;

    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_adr = '0; m0_wdin = '0;
    m1_req = 0; m1_we = 0; m1_adr = '0; m1_wdin = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // m0 read of 0x10
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_adr = 32'h10;
    #1;
    chk("rd_m0_gnt", a_m0_gnt, 1);
    chk("rd_m1_gnt", a_m1_gnt, 0);
    @(negedge clk);
    m0_req = 0; m0_adr = 32'hFFFF_FFFC;
    #1;
    chk("rd_acc_adr", a_dram_adr, 32'h10);
    chk("rd_acc_we", a_dram_we, 0);
    chk("rd_acc_gnt", a_m0_gnt, 0);
    chk("rd_acc_m1done", a_m1_done, 0);
    @(negedge clk); #1;
    chk("rd_done", a_m0_done, 1);
    chk("rd_data", a_m0_rd, 32'hDEADBEEF);
    chk("rd_m1done", a_m1_done, 0);

    // m1 write 0x12345678 -> 0x20, then m0 reads it back-to-back
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_adr = 32'h20; m1_wdin = 32'h12345678;
    #1;
    chk("wr_m1_gnt", a_m1_gnt, 1);
    chk("wr_idle_m0done", a_m0_done, 0);
    @(negedge clk);
    m1_req = 0; m1_wdin = '0;
    #1;
    chk("wr_acc_we", a_dram_we, 1);
    chk("wr_acc_wdin", a_dram_wdin, 32'h12345678);
    chk("wr_acc_adr", a_dram_adr, 32'h20);
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_adr = 32'h20;
    #1;
    chk("wr_done", a_m1_done, 1);
    chk("wr_rd_zero", a_m1_rd, 0);
    chk("wr_done_we", a_dram_we, 0);
    chk("wr_owner", a_owner, 1);
    chk("b2b_m0_gnt", a_m0_gnt, 1);
    @(negedge clk);
    m0_req = 0;
    #1;
    chk("b2b_acc_we", a_dram_we, 0);
    chk("b2b_acc_gnt", a_m0_gnt, 0);
    chk("b2b_owner", a_owner, 0);
    @(negedge clk); #1;
    chk("b2b_done", a_m0_done, 1);
    chk("b2b_data", a_m0_rd, 32'h12345678);

    // Reset with both requests high, then sustained contention
    @(negedge clk);
    rst = 1;
    m0_req = 1; m0_we = 0; m0_adr = 32'h10;
    m1_req = 1; m1_we = 0; m1_adr = 32'h20;
    #1;
    chk("rst_a_g0", a_m0_gnt, 0);
    chk("rst_a_g1", a_m1_gnt, 0);
    chk("rst_b_g0", b_m0_gnt, 0);
    chk("rst_b_g1", b_m1_gnt, 0);
    @(negedge clk); #1;
    chk("rst2_a_g0", a_m0_gnt, 0);
    chk("rst2_b_g1", b_m1_gnt, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_we", a_dram_we, 0);
    chk("post_rst_adr", a_dram_adr, 0);
    chk("post_rst_d0", a_m0_done, 0);
    chk("post_rst_d1", a_m1_done, 0);
    chk("post_rst_owner", a_owner, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      chk($sformatf("rr_g0_c%0d", i), a_m0_gnt, a_g0_t[i]);
      chk($sformatf("rr_g1_c%0d", i), a_m1_gnt, a_g1_t[i]);
      chk($sformatf("rr_d0_c%0d", i), a_m0_done, a_d0_t[i]);
      chk($sformatf("rr_d1_c%0d", i), a_m1_done, a_d1_t[i]);
      chk($sformatf("rr_onegnt_c%0d", i), a_m0_gnt & a_m1_gnt, 0);
      chk($sformatf("fx_g0_c%0d", i), b_m0_gnt, b_g0_t[i]);
      chk($sformatf("fx_g1_c%0d", i), b_m1_gnt, 0);
      chk($sformatf("fx_d0_c%0d", i), b_m0_done, b_d0_t[i]);
      chk($sformatf("fx_d1_c%0d", i), b_m1_done, 0);
      if (i == 2) chk("fx_m0_rd", b_m0_rd, 32'hDEADBEEF);
    end
    // m0 drops: starved m1 wins the very next arbitration
    @(negedge clk);
    m0_req = 0;
    #1;
    chk("fx_m1_gnt", b_m1_gnt, 1);
    chk("fx_m0_gnt", b_m0_gnt, 0);
    chk("rr_c8_d1", a_m1_done, 1);
    chk("rr_c8_g1", a_m1_gnt, 1);
    @(negedge clk);
    m1_req = 0;
    #1;
    chk("fx_acc_adr", b_dram_adr, 32'h20);
    chk("fx_owner", b_owner, 1);
    @(negedge clk); #1;
    chk("fx_m1_done", b_m1_done, 1);
    chk("fx_m1_rd", b_m1_rd, 32'h12345678);

    // Reset during ACCESS of an m1 write to 0x40
    @(negedge clk);
    rst = 1;
    #1;
    @(negedge clk);
    rst = 0;
    m1_req = 1; m1_we = 1; m1_adr = 32'h40; m1_wdin = 32'hCAFEF00D;
    #1;
    chk("abort_gnt", a_m1_gnt, 1);
    @(negedge clk);
    m1_req = 0;
    #1;
    chk("abort_acc_we", a_dram_we, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_we", a_dram_we, 0);
    chk("abort_done", a_m1_done, 0);
    chk("abort_adr", a_dram_adr, 0);
    chk("abort_owner", a_owner, 0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #1;
      chk($sformatf("abort_we_%0d", j), a_dram_we, 0);
      chk($sformatf("abort_done_%0d", j), a_m1_done, 0);
    end
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_adr = 32'h40;
    #1;
    chk("abort_idle_gnt", a_m0_gnt, 1);
    @(negedge clk);
    m0_req = 0;
    #1;
    chk("abort_rd_we", a_dram_we, 0);
    @(negedge clk); #1;
    chk("abort_rd_done", a_m0_done, 1);
    chk("abort_rd_m1done", a_m1_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
